// File: rtl/twi_mon_pkg.sv
// Shared types and helpers for the TWI frame serializer: FSM states, symbol kinds,
// the debug view exported by the top level, and the nibble-to-ASCII encoder.
package twi_mon_pkg;

    typedef enum logic [1:0] {IDLE, START, SEND} state_t;

    typedef enum logic [1:0] {SYM_ADDR, SYM_DATA, SYM_ACKS, SYM_TERM} sym_kind_t;

    localparam int MAX_BYTES_LIMIT = 7;

    // Wide enough for the longest frame: hex, 7 data bytes, terminator = 19 symbols.
    localparam int IDX_W = 5;

    typedef struct packed {
        state_t           state;
        logic [IDX_W-1:0] index;
        sym_kind_t        kind;
        logic [2:0]       byte_sel;
        logic             nibble_lo;
    } dbg_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/twi_symbol_mux.sv
// Combinational symbol selector: turns the symbol index and captured frame into
// the symbol kind, data byte / nibble selection and the byte presented to the UART.
module twi_symbol_mux
    import twi_mon_pkg::*;
#(
    parameter int         MAX_BYTES  = 4,
    parameter int         CW         = 3,
    parameter int         HEX_MODE   = 0,
    parameter logic [7:0] TERMINATOR = 8'h0A
) (
    input  logic [IDX_W-1:0]       index,
    input  logic [CW-1:0]          count,
    input  logic [7:0]             addr,
    input  logic                   addr_ack,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [MAX_BYTES-1:0]   acks,
    output sym_kind_t              kind,
    output logic [2:0]             byte_sel,
    output logic                   nibble_lo,
    output logic [7:0]             tx_feed
);

    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] count_w;
    logic [7:0]       data_byte;
    logic [7:0]       ack_byte;
    logic [7:0]       sym_byte;

    always_comb begin
        count_w   = IDX_W'(count);
        // In hex mode every byte occupies two consecutive symbol slots.
        pos       = (HEX_MODE != 0) ? (index >> 1) : index;
        nibble_lo = (HEX_MODE != 0) ? index[0] : 1'b0;

        kind     = SYM_TERM;
        byte_sel = '0;
        if (pos == '0) begin
            kind = SYM_ADDR;
        end else if (pos <= count_w) begin
            kind     = SYM_DATA;
            byte_sel = 3'(pos - ONE);
        end else if (pos == count_w + ONE) begin
            kind = SYM_ACKS;
        end

        data_byte = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (byte_sel == 3'(i)) data_byte = data[8*(MAX_BYTES-i)-1 -: 8];
        end

        ack_byte    = '0;
        ack_byte[7] = addr_ack;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(count)) ack_byte[i] = acks[i];
        end

        case (kind)
            SYM_ADDR: sym_byte = addr;
            SYM_DATA: sym_byte = data_byte;
            SYM_ACKS: sym_byte = ack_byte;
            default:  sym_byte = 8'h00;
        endcase

        // The terminator is always sent verbatim, even in hex mode.
        if (kind == SYM_TERM)   tx_feed = TERMINATOR;
        else if (HEX_MODE != 0) tx_feed = nibble_to_ascii(nibble_lo ? sym_byte[3:0] : sym_byte[7:4]);
        else                    tx_feed = sym_byte;
    end

endmodule

// File: rtl/twi_frame_serializer.sv
// Captures a whole TWI transaction in one cycle and streams it to a UART TX as
// ADDR, DATA[0..count-1], ACKS and an optional terminator, raw or as ASCII hex.
module twi_frame_serializer
    import twi_mon_pkg::*;
#(
    parameter int         MAX_BYTES  = 4,
    parameter int         HEX_MODE   = 0,
    parameter int         TERM_EN    = 1,
    parameter logic [7:0] TERMINATOR = 8'h0A,
    localparam int        CW         = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [7:0]             frame_addr,
    input  logic                   addr_ack,
    input  logic [8*MAX_BYTES-1:0] frame_data,
    input  logic [MAX_BYTES-1:0]   data_acks,
    input  logic [CW-1:0]          byte_count,
    input  logic                   new_data_ready,
    input  logic                   tx_busy,
    output logic [7:0]             tx_feed,
    output logic                   tx_start,
    output logic                   tx_available,
    output logic [7:0]             drop_count,
    output dbg_t                   dbg
);

    if (MAX_BYTES < 1 || MAX_BYTES > MAX_BYTES_LIMIT) begin : g_bad_max_bytes
        $error("twi_frame_serializer: MAX_BYTES must be 1..%0d", MAX_BYTES_LIMIT);
    end

    localparam logic [IDX_W-1:0] TERM_W = IDX_W'(TERM_EN != 0);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] TWO    = IDX_W'(2);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       index_q;
    logic [7:0]             addr_q;
    logic                   addr_ack_q;
    logic [8*MAX_BYTES-1:0] data_q;
    logic [MAX_BYTES-1:0]   acks_q;
    logic [CW-1:0]          count_q;
    logic [7:0]             drop_q;
    logic [IDX_W-1:0]       last_idx;
    logic                   last_sym;
    logic                   capture;
    logic                   drop;
    sym_kind_t              kind;
    logic [2:0]             byte_sel;
    logic                   nibble_lo;
    logic [7:0]             mux_feed;

    assign capture  = enable && new_data_ready && (state_q == IDLE);
    assign drop     = enable && new_data_ready && (state_q != IDLE);
    assign last_idx = (HEX_MODE != 0) ? (((IDX_W'(count_q) + TWO) << 1) + TERM_W - ONE)
                                      : (IDX_W'(count_q) + TWO + TERM_W - ONE);
    assign last_sym = (index_q == last_idx);

    always_ff @(posedge clk) begin
        if (reset)       state_q <= IDLE;
        else if (enable) state_q <= state_d;
    end

    // Handshake: START raises tx_start with the symbol on tx_feed and waits for
    // tx_busy=1 (acceptance, possibly already high); SEND then waits for tx_busy=0
    // (symbol done) before advancing. tx_feed is stable across START and SEND.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = START;
            START:   if (tx_busy) state_d = SEND;
            SEND:    if (!tx_busy) state_d = last_sym ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start     = (state_q == START);
        tx_available = (state_q == IDLE);
        tx_feed      = (state_q == IDLE) ? 8'h00 : mux_feed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= '0;
        end else if (enable) begin
            if (capture)                          index_q <= '0;
            else if (state_q == SEND && !tx_busy) index_q <= last_sym ? '0 : index_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            addr_ack_q <= 1'b0;
            data_q     <= '0;
            acks_q     <= '0;
            count_q    <= '0;
        end else if (capture) begin
            addr_q     <= frame_addr;
            addr_ack_q <= addr_ack;
            data_q     <= frame_data;
            acks_q     <= data_acks;
            count_q    <= (byte_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : byte_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                         drop_q <= '0;
        else if (drop && drop_q != 8'hFF)  drop_q <= drop_q + 8'd1;
    end

    assign drop_count = drop_q;

    twi_symbol_mux #(
        .MAX_BYTES (MAX_BYTES),
        .CW        (CW),
        .HEX_MODE  (HEX_MODE),
        .TERMINATOR(TERMINATOR)
    ) u_mux (
        .index    (index_q),
        .count    (count_q),
        .addr     (addr_q),
        .addr_ack (addr_ack_q),
        .data     (data_q),
        .acks     (acks_q),
        .kind     (kind),
        .byte_sel (byte_sel),
        .nibble_lo(nibble_lo),
        .tx_feed  (mux_feed)
    );

    assign dbg = '{state: state_q, index: index_q, kind: kind, byte_sel: byte_sel, nibble_lo: nibble_lo};

endmodule

// File: tb/tb_twi_frame_serializer.sv
// Bench for twi_frame_serializer: a raw+terminator instance and a hex instance,
// each with a UART busy responder and an expected-symbol queue.
module tb_twi_frame_serializer;
    import twi_mon_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable;
    logic [7:0]  frame_addr;
    logic        addr_ack;
    logic [31:0] frame_data;
    logic [3:0]  data_acks;
    logic [2:0]  byte_count;
    logic        ndr_raw, ndr_hex;
    logic        busy_raw_m, busy_hold, busy_hex;
    logic        tx_busy_raw;
    logic [7:0]  feed_raw, feed_hex, drop_raw, drop_hex;
    logic        start_raw, start_hex, avail_raw, avail_hex;
    dbg_t        dbg_raw, dbg_hex;

    assign tx_busy_raw = busy_raw_m | busy_hold;

    twi_frame_serializer #(.MAX_BYTES(4), .HEX_MODE(0), .TERM_EN(1), .TERMINATOR(8'h0A)) dut_raw (
        .clk(clk), .reset(reset), .enable(enable), .frame_addr(frame_addr), .addr_ack(addr_ack),
        .frame_data(frame_data), .data_acks(data_acks), .byte_count(byte_count),
        .new_data_ready(ndr_raw), .tx_busy(tx_busy_raw), .tx_feed(feed_raw), .tx_start(start_raw),
        .tx_available(avail_raw), .drop_count(drop_raw), .dbg(dbg_raw)
    );

    twi_frame_serializer #(.MAX_BYTES(4), .HEX_MODE(1), .TERM_EN(0), .TERMINATOR(8'h0A)) dut_hex (
        .clk(clk), .reset(reset), .enable(enable), .frame_addr(frame_addr), .addr_ack(addr_ack),
        .frame_data(frame_data), .data_acks(data_acks), .byte_count(byte_count),
        .new_data_ready(ndr_hex), .tx_busy(busy_hex), .tx_feed(feed_hex), .tx_start(start_hex),
        .tx_available(avail_hex), .drop_count(drop_hex), .dbg(dbg_hex)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART model: accept a start request, stay busy for three cycles.
    int cnt_raw, cnt_hex;
    always @(negedge clk) begin
        if (reset) begin
            busy_raw_m = 1'b0; cnt_raw = 0;
        end else if (busy_raw_m) begin
            cnt_raw--;
            if (cnt_raw == 0) busy_raw_m = 1'b0;
        end else if (start_raw) begin
            busy_raw_m = 1'b1; cnt_raw = 3;
        end
    end
    always @(negedge clk) begin
        if (reset) begin
            busy_hex = 1'b0; cnt_hex = 0;
        end else if (busy_hex) begin
            cnt_hex--;
            if (cnt_hex == 0) busy_hex = 1'b0;
        end else if (start_hex) begin
            busy_hex = 1'b1; cnt_hex = 3;
        end
    end

    // Scoreboard: each new tx_start interval consumes one expected symbol.
    logic [7:0] exp_raw_q[$];
    logic [7:0] exp_hex_q[$];
    int   starts_raw = 0, starts_hex = 0;
    logic prev_raw = 1'b0, prev_hex = 1'b0;
    always @(negedge clk) begin
        #1;
        if (start_raw && !prev_raw) begin
            starts_raw++;
            check("raw_sym_expected", 32'(exp_raw_q.size() != 0), 32'd1);
            if (exp_raw_q.size() != 0) check("raw_sym", 32'(feed_raw), 32'(exp_raw_q.pop_front()));
        end
        if (start_hex && !prev_hex) begin
            starts_hex++;
            check("hex_sym_expected", 32'(exp_hex_q.size() != 0), 32'd1);
            if (exp_hex_q.size() != 0) check("hex_sym", 32'(feed_hex), 32'(exp_hex_q.pop_front()));
        end
        prev_raw = start_raw;
        prev_hex = start_hex;
    end

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n <= 4'd9) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    endfunction

    task automatic push_model(input bit hex, input bit term, input logic [7:0] a, input logic aa,
                              input logic [31:0] d, input logic [3:0] ak, input logic [2:0] c);
        logic [7:0] b[$];
        logic [7:0] ackb;
        int n;
        n = (c > 3'd4) ? 4 : int'(c);
        b.push_back(a);
        for (int i = 0; i < n; i++) b.push_back(d[31-8*i -: 8]);
        ackb = {aa, 7'b0};
        for (int i = 0; i < n; i++) ackb[i] = ak[i];
        b.push_back(ackb);
        foreach (b[k]) begin
            if (hex) begin
                exp_hex_q.push_back(asc(b[k][7:4]));
                exp_hex_q.push_back(asc(b[k][3:0]));
            end else begin
                exp_raw_q.push_back(b[k]);
            end
        end
        if (term) begin
            if (hex) exp_hex_q.push_back(8'h0A);
            else     exp_raw_q.push_back(8'h0A);
        end
    endtask

    task automatic drive_frame(input logic [7:0] a, input logic aa, input logic [31:0] d,
                               input logic [3:0] ak, input logic [2:0] c);
        frame_addr = a; addr_ack = aa; frame_data = d; data_acks = ak; byte_count = c;
    endtask

    task automatic pulse_raw();
        @(negedge clk); #1; ndr_raw = 1'b1;
        @(negedge clk); #1; ndr_raw = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] a, input logic aa, input logic [31:0] d,
                            input logic [3:0] ak, input logic [2:0] c);
        drive_frame(a, aa, d, ak, c);
        push_model(1'b0, 1'b1, a, aa, d, ak, c);
        pulse_raw();
    endtask

    task automatic wait_idle(input bit hex, input string tag);
        int n = 0;
        while (n < 400 && (hex ? (exp_hex_q.size() != 0 || !avail_hex)
                               : (exp_raw_q.size() != 0 || !avail_raw))) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_done_in_time"}, 32'(n < 400), 32'd1);
        check({tag, "_available"}, 32'(hex ? avail_hex : avail_raw), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; ndr_raw = 1'b0; ndr_hex = 1'b0; busy_hold = 1'b0;
        drive_frame(8'h00, 1'b0, 32'h0, 4'h0, 3'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_start", 32'(start_raw), 32'd0);
        check("rst_feed", 32'(feed_raw), 32'h00);
        check("rst_avail", 32'(avail_raw), 32'd1);
        check("rst_drop", 32'(drop_raw), 32'd0);
        check("rst_state", 32'(dbg_raw.state), 32'(IDLE));
        check("rst_hex_feed", 32'(feed_hex), 32'h00);
        reset = 1'b0;

        // Basic raw frame: 22,77,10,81,0A
        starts_raw = 0;
        send_raw(8'h22, 1'b1, 32'h7710_0000, 4'b0001, 3'd2);
        check("cap_start", 32'(start_raw), 32'd1);
        check("cap_avail", 32'(avail_raw), 32'd0);
        wait_idle(1'b0, "raw_basic");
        check("raw_basic_starts", 32'(starts_raw), 32'd5);

        // Hex frame: "A53C01"
        starts_hex = 0;
        drive_frame(8'hA5, 1'b0, 32'h3C00_0000, 4'b0001, 3'd1);
        push_model(1'b1, 1'b0, 8'hA5, 1'b0, 32'h3C00_0000, 4'b0001, 3'd1);
        @(negedge clk); #1; ndr_hex = 1'b1;
        @(negedge clk); #1; ndr_hex = 1'b0;
        wait_idle(1'b1, "hex_basic");
        check("hex_basic_starts", 32'(starts_hex), 32'd6);

        // Boundary counts: zero data bytes, and a count above MAX_BYTES
        starts_raw = 0;
        send_raw(8'h50, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'd0);
        wait_idle(1'b0, "raw_cnt0");
        check("raw_cnt0_starts", 32'(starts_raw), 32'd3);
        send_raw(8'hC3, 1'b1, 32'hDEAD_BEEF, 4'b1010, 3'd7);
        wait_idle(1'b0, "raw_cnt7");
        check("raw_cnt7_starts", 32'(starts_raw), 32'd10);

        for (int k = 0; k < 4; k++) begin
            send_raw(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 32'($urandom),
                     4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            wait_idle(1'b0, "raw_rand");
        end

        // Frame changes and drops while busy must not affect the captured frame
        send_raw(8'h5A, 1'b1, 32'h1122_3344, 4'b1111, 3'd4);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive_frame(8'($urandom_range(0, 255)), 1'b0, 32'($urandom), 4'h0, 3'd3);
            pulse_raw();
            repeat (2) @(negedge clk);
        end
        check("drop_three", 32'(drop_raw), 32'd3);
        wait_idle(1'b0, "raw_drops");

        // Drop counter saturation with the UART held busy
        send_raw(8'h11, 1'b0, 32'h0, 4'h0, 3'd1);
        busy_hold = 1'b1;
        ndr_raw = 1'b1;
        repeat (260) @(negedge clk);
        #1; ndr_raw = 1'b0;
        @(negedge clk); #1;
        check("drop_saturate", 32'(drop_raw), 32'd255);
        busy_hold = 1'b0;
        wait_idle(1'b0, "raw_sat");

        // Reset while DATA[0] is in SEND
        starts_raw = 0;
        send_raw(8'h81, 1'b1, 32'h6655_0000, 4'b0011, 3'd2);
        begin
            int n = 0;
            while (n < 200 && !(starts_raw == 2 && dbg_raw.state == SEND)) begin
                @(negedge clk); #1; n++;
            end
            check("rst_mid_reach_send", 32'(n < 200), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        check("rst_mid_state", 32'(dbg_raw.state), 32'(IDLE));
        check("rst_mid_start", 32'(start_raw), 32'd0);
        check("rst_mid_feed", 32'(feed_raw), 32'h00);
        check("rst_mid_drop", 32'(drop_raw), 32'd0);
        exp_raw_q.delete();
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst_mid_no_more", 32'(starts_raw), 32'd2);

        // Back-to-back: pulse on the return-to-IDLE cycle drops, next cycle captures
        send_raw(8'h3C, 1'b0, 32'h0, 4'h0, 3'd0);
        begin
            int n = 0;
            while (n < 200 && !(exp_raw_q.size() == 0 && dbg_raw.state == SEND && !tx_busy_raw)) begin
                @(negedge clk); #1; n++;
            end
            check("b2b_reach_last", 32'(n < 200), 32'd1);
        end
        drive_frame(8'h7E, 1'b1, 32'hA1B2_C3D4, 4'b0110, 3'd3);
        ndr_raw = 1'b1;
        @(negedge clk); #1;
        check("b2b_idle", 32'(avail_raw), 32'd1);
        push_model(1'b0, 1'b1, 8'h7E, 1'b1, 32'hA1B2_C3D4, 4'b0110, 3'd3);
        @(negedge clk); #1;
        ndr_raw = 1'b0;
        check("b2b_captured", 32'(start_raw), 32'd1);
        check("b2b_drop", 32'(drop_raw), 32'd1);
        wait_idle(1'b0, "raw_b2b");
        check("b2b_drop_after", 32'(drop_raw), 32'd1);

        // enable=0 freezes the FSM in START, transfer resumes afterwards
        send_raw(8'h99, 1'b0, 32'h4242_0000, 4'b0001, 3'd1);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ndr_raw = (k == 2);
            @(negedge clk); #1;
            check("frz_state", 32'(dbg_raw.state), 32'(START));
            check("frz_feed", 32'(feed_raw), 32'h99);
        end
        ndr_raw = 1'b0;
        check("frz_drop", 32'(drop_raw), 32'd1);
        enable = 1'b1;
        wait_idle(1'b0, "raw_frz");

        check("raw_q_empty", 32'(exp_raw_q.size()), 32'd0);
        check("hex_q_empty", 32'(exp_hex_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twi_frame_serializer.md
Name: twi_frame_serializer

Overview:
- Parametrised successor to the TWI frame-to-UART presenter.
- Latches a complete TWI transaction in one cycle: address byte, address ACK, up to MAX_BYTES data bytes with per-byte ACKs, and a byte count.
- Streams the transaction to the UART transmitter as a symbol sequence through a start/busy handshake. Output is raw binary or ASCII hex, with an optional terminator.
- Sits between the TWI frame assembler and the UART TX. The captured buffer decouples the input frame from transmission, so input changes mid-send cannot corrupt output.

Parameters:
- MAX_BYTES, 4, maximum data bytes per frame; legal range 1..7.
- HEX_MODE, 0, 0 = each byte sent raw; 1 = each byte sent as two uppercase ASCII hex chars, high nibble first.
- TERM_EN, 1, 1 = append terminator symbol after the ACK symbol(s).
- TERMINATOR, 8'h0A, terminator character.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  0 freezes all state, counters and capture
- frame_addr  in  8  TWI address byte (including R/W bit)
- addr_ack  in  1  ACK bit following the address
- frame_data  in  8*MAX_BYTES  data bytes; byte 0 = [8*MAX_BYTES-1 -: 8], byte i = [8*(MAX_BYTES-i)-1 -: 8]
- data_acks  in  MAX_BYTES  ACK bit of byte i at bit i
- byte_count  in  $clog2(MAX_BYTES+1)  valid data bytes in the frame
- new_data_ready  in  1  one-cycle pulse: frame inputs valid
- tx_busy  in  1  UART transmitter busy
- tx_feed  out  8  symbol presented to the UART
- tx_start  out  1  request UART to start sending tx_feed
- tx_available  out  1  high when idle and able to accept a frame
- drop_count  out  8  saturating count of frames dropped while busy

Behaviour:
- Clocking and reset:
  - Clock clk; reset is synchronous, active-high.
  - Reset forces state IDLE, symbol index 0, drop_count 0, and the capture buffer to 0.
  - Outputs during reset and IDLE: tx_start=0, tx_feed=8'h00, tx_available=1.
  - Reset mid-transmission aborts at the next edge. Remaining symbols are not sent; tx_start=0 from the following cycle.
- enable=0: state, index, buffer and drop_count hold. Outputs remain the combinational function of held state.
- Capture:
  - Condition: state IDLE, enable=1, new_data_ready=1.
  - Action: register all frame inputs and clamp count = min(byte_count, MAX_BYTES).
  - Next state START with index 0; tx_start is high the cycle after the pulse.
- Drop: new_data_ready=1 with enable=1 in any state other than IDLE increments drop_count, saturating at 255. The frame is ignored.
- Symbol order:
  - ADDR, then DATA[0..count-1], then ACKS, then TERM if TERM_EN.
  - count=0 skips all DATA symbols.
- ACK byte: bit7 = addr_ack; bit i (i < count) = data_acks[i]; all other bits 0.
- Symbol count per frame:
  - Raw: 2+count+TERM_EN.
  - Hex: 2*(2+count)+TERM_EN. Each byte becomes hi-nibble char then lo-nibble char (0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46). TERM is never hex-encoded.
- FSM:
  - IDLE -> START on capture.
  - START: tx_start=1, tx_feed=current symbol. Go to SEND when tx_busy=1; otherwise stay.
  - SEND: tx_start=0, tx_feed holds current symbol. When tx_busy=0: if last symbol, go to IDLE (index cleared); else increment index and go to START.
- tx_feed is combinational from state, index and buffer, and is stable for the whole START+SEND of a symbol.
- tx_busy already high on entry to START counts as accepted: START lasts one cycle.
- tx_available = (state==IDLE).

Decomposition:
- Package twi_mon_pkg holds:
  - state enum {IDLE, START, SEND};
  - symbol-kind enum {SYM_ADDR, SYM_DATA, SYM_ACKS, SYM_TERM};
  - localparam MAX_BYTES_LIMIT=7;
  - function nibble_to_ascii.
- Sub-module twi_symbol_mux (combinational): maps index, count, mode and buffer to symbol kind, byte select, nibble select and tx_feed.
- Top level holds the FSM, capture registers and drop counter.

Test Plan:
- Raw, MAX_BYTES=4, TERM_EN=1: addr=8'h22, addr_ack=1, count=2, data 8'h77,8'h10, acks=2'b01; tx_busy model 3 cycles high per symbol -> tx_feed sequence 22,77,10,81,0A. Exactly 5 tx_start intervals; tx_available returns 1 after the last busy falls.
- HEX_MODE=1, TERM_EN=0: addr=8'hA5, ack=0, count=1, data 8'h3C, ack 1 -> symbols 41,35,33,43,30,31 ("A53C01").
- count=0 and count=7 with MAX_BYTES=4: count=0 -> ADDR,ACKS(,TERM) only; count=7 clamps to 4 data symbols.
- Frame change and drops: change frame inputs and pulse new_data_ready 3 times mid-transmission -> output still carries the captured frame; drop_count=3. Force 260 drops -> drop_count stays 255.
- Reset in SEND of DATA[0] -> next cycle IDLE, tx_start=0, tx_feed=00, drop_count=0. enable=0 held 5 cycles in START -> state and tx_feed unchanged, and the transfer resumes after enable returns.
- Back-to-back: new_data_ready in the same cycle the FSM returns to IDLE is dropped; a pulse one cycle later is captured with no extra drop counted.
